// File: rtl/pong_ball_engine.sv
// Multi-ball pong physics, serve control, scoring and IDLE/PLAY/OVER game state.
// Build macro SPIN_DEFLECT_EN: per-ball vertical speed set by where the ball meets a paddle.
module pong_ball_engine #(
   parameter int NUM_BALLS    = 4,
   parameter int BALL_SIZE    = 8,
   parameter int SCREEN_W     = 640,
   parameter int SCREEN_H     = 480,
   parameter int TOP_MARGIN   = 25,
   parameter int PADDLE_H     = 72,
   parameter int SCORE_LIMIT  = 5,
   parameter int SPEED_MIN    = 2,
   parameter int SPEED_MAX    = 5,
   parameter int SPEED_PERIOD = 600,
   parameter int SERVE_DELAY  = 60
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    refresh_tick,
   input  logic                    game_active,
   input  logic [NUM_BALLS-1:0]    ball_enable,
   input  logic [9:0]              paddle1_y,
   input  logic [9:0]              paddle2_y,
   output logic [10*NUM_BALLS-1:0] ball_x,
   output logic [10*NUM_BALLS-1:0] ball_y,
   output logic [NUM_BALLS-1:0]    ball_visible,
   output logic [3:0]              score_player1,
   output logic [3:0]              score_player2,
   output logic [3:0]              speed,
   output logic                    game_over,
   output logic                    point_pulse,
   output logic                    point_side
);

   localparam int SCW  = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
   localparam int TCW  = (SPEED_PERIOD > 1) ? $clog2(SPEED_PERIOD) : 1;
   localparam int IDXW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;

   localparam logic [9:0]         CX       = 10'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [9:0]         CY       = 10'((SCREEN_H + TOP_MARGIN - BALL_SIZE) / 2);
   localparam logic [9:0]         TOP_Y    = 10'(TOP_MARGIN);
   localparam logic [9:0]         BOT_Y    = 10'(SCREEN_H - BALL_SIZE);
   localparam logic [9:0]         L_CLAMP  = 10'd41;
   localparam logic [9:0]         R_CLAMP  = 10'(599 - BALL_SIZE);
   localparam logic signed [10:0] TOP_S    = 11'(TOP_MARGIN);
   localparam logic signed [10:0] BOT_S    = 11'(SCREEN_H - BALL_SIZE);
   localparam logic signed [10:0] XMAX_S   = 11'(SCREEN_W - BALL_SIZE);
   localparam logic signed [10:0] BS_S     = 11'(BALL_SIZE);
   localparam logic signed [10:0] L_BACK   = 11'sd32;
   localparam logic signed [10:0] L_FACE   = 11'sd40;
   localparam logic signed [10:0] R_FACE   = 11'sd600;
   localparam logic signed [10:0] R_BACK   = 11'sd608;
   localparam logic [10:0]        TOP_U    = 11'(TOP_MARGIN);
   localparam logic [10:0]        PH_U     = 11'(PADDLE_H);
   localparam logic [3:0]         SPD_MIN  = 4'(SPEED_MIN);
   localparam logic [3:0]         SPD_MAX  = 4'(SPEED_MAX);
   localparam logic [3:0]         LIMIT    = 4'(SCORE_LIMIT);
   localparam logic [SCW-1:0]     SERVE_LAST = SCW'(SERVE_DELAY - 1);
   localparam logic [TCW-1:0]     STEP_LAST  = TCW'(SPEED_PERIOD - 1);

   typedef enum logic [1:0] {G_IDLE = 2'b00, G_PLAY = 2'b01, G_OVER = 2'b10} game_state_t;
   // bit 0 of the ball state doubles as the visibility flag
   typedef enum logic [1:0] {B_PARKED = 2'b00, B_SERVE = 2'b01, B_MOVE = 2'b11} ball_state_t;

   game_state_t          game_r;
   logic                 active_d_r;
   ball_state_t          bstate_r    [NUM_BALLS];
   logic [9:0]           bx_r        [NUM_BALLS];
   logic [9:0]           by_r        [NUM_BALLS];
   logic [SCW-1:0]       serve_cnt_r [NUM_BALLS];
   logic [NUM_BALLS-1:0] dx_left_r;
   logic [NUM_BALLS-1:0] dy_up_r;
   logic [3:0]           score1_r;
   logic [3:0]           score2_r;
   logic [3:0]           speed_r;
   logic [TCW-1:0]       tick_cnt_r;
   logic                 game_over_r;
   logic                 point_pulse_r;
   logic                 point_side_r;

   logic [3:0]           dy_mag_s    [NUM_BALLS];
   logic signed [10:0]   nx_s        [NUM_BALLS];
   logic signed [10:0]   ny_s        [NUM_BALLS];
   logic [NUM_BALLS-1:0] hit_l_s;
   logic [NUM_BALLS-1:0] hit_r_s;
   logic [NUM_BALLS-1:0] out_l_s;
   logic [NUM_BALLS-1:0] out_r_s;
   logic                 score_found_s;
   logic [IDXW-1:0]      score_idx_s;
   logic                 score_left_s;

`ifdef SPIN_DEFLECT_EN
   logic [3:0] dy_mag_r   [NUM_BALLS];
   logic [3:0] spin_mag_s [NUM_BALLS];
   logic [3:0] spd_up_s;
   logic [3:0] spd_dn_s;
   localparam logic [10:0] PQ_U = 11'(PADDLE_H / 4);

   assign spd_up_s = (speed_r == 4'd15) ? 4'd15 : (speed_r + 4'd1);
   assign spd_dn_s = (speed_r > 4'd1) ? (speed_r - 4'd1) : 4'd1;
`endif

   function automatic logic serve_left(input int idx);
      return (idx % 2) == 0;
   endfunction

   function automatic logic serve_up(input int idx);
      return ((idx / 2) % 2) == 1;
   endfunction

   for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
      logic signed [10:0] x_s;
      logic signed [10:0] y_s;
      logic signed [10:0] xstep_s;
      logic signed [10:0] ystep_s;
      logic [10:0]        yu_s;
      logic [10:0]        top1_s;
      logic [10:0]        top2_s;
      logic               in_p1_s;
      logic               in_p2_s;

      assign x_s      = $signed({1'b0, bx_r[g]});
      assign y_s      = $signed({1'b0, by_r[g]});
      assign xstep_s  = $signed({7'b0, speed_r});
      assign ystep_s  = $signed({7'b0, dy_mag_s[g]});
      assign nx_s[g]  = dx_left_r[g] ? (x_s - xstep_s) : (x_s + xstep_s);
      assign ny_s[g]  = dy_up_r[g] ? (y_s - ystep_s) : (y_s + ystep_s);

      // paddle spans are checked against the ball's current row
      assign yu_s     = {1'b0, by_r[g]};
      assign top1_s   = {1'b0, paddle1_y} + TOP_U;
      assign top2_s   = {1'b0, paddle2_y} + TOP_U;
      assign in_p1_s  = (yu_s >= top1_s) && (yu_s <= (top1_s + PH_U));
      assign in_p2_s  = (yu_s >= top2_s) && (yu_s <= (top2_s + PH_U));

      assign hit_l_s[g] = dx_left_r[g] && (x_s >= L_BACK) && (nx_s[g] <= L_FACE) && in_p1_s;
      assign hit_r_s[g] = !dx_left_r[g] && ((x_s + BS_S) <= R_BACK) &&
                          ((nx_s[g] + BS_S) >= R_FACE) && in_p2_s;
      assign out_l_s[g] = !hit_l_s[g] && (nx_s[g] < 11'sd0);
      assign out_r_s[g] = !hit_r_s[g] && (nx_s[g] > XMAX_S);

      assign ball_x[10*g +: 10] = bx_r[g];
      assign ball_y[10*g +: 10] = by_r[g];
      assign ball_visible[g]    = bstate_r[g][0];

`ifdef SPIN_DEFLECT_EN
      logic [10:0] rel_s;
      assign dy_mag_s[g]   = dy_mag_r[g];
      assign rel_s         = hit_l_s[g] ? (yu_s - top1_s) : (yu_s - top2_s);
      assign spin_mag_s[g] = ((rel_s < PQ_U) || (rel_s > (PH_U - PQ_U))) ? spd_up_s : spd_dn_s;
`else
      assign dy_mag_s[g]   = speed_r;
`endif
   end

   // Pick the lowest-index moving ball that leaves the field on this tick.
   always_comb begin
      score_found_s = 1'b0;
      score_idx_s   = '0;
      score_left_s  = 1'b0;
      for (int i = NUM_BALLS - 1; i >= 0; i--) begin
         if (ball_enable[i] && (bstate_r[i] == B_MOVE) && (out_l_s[i] || out_r_s[i])) begin
            score_found_s = 1'b1;
            score_idx_s   = IDXW'(i);
            score_left_s  = out_l_s[i];
         end else begin
            score_found_s = score_found_s;
         end
      end
   end

   // Game state, per-ball serve/move machines, scores and speed schedule.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         game_r        <= G_IDLE;
         active_d_r    <= 1'b0;
         score1_r      <= 4'd0;
         score2_r      <= 4'd0;
         speed_r       <= SPD_MIN;
         tick_cnt_r    <= '0;
         game_over_r   <= 1'b0;
         point_pulse_r <= 1'b0;
         point_side_r  <= 1'b0;
         for (int i = 0; i < NUM_BALLS; i++) begin
            bstate_r[i]    <= B_PARKED;
            bx_r[i]        <= CX;
            by_r[i]        <= CY;
            serve_cnt_r[i] <= '0;
            dx_left_r[i]   <= serve_left(i);
            dy_up_r[i]     <= serve_up(i);
`ifdef SPIN_DEFLECT_EN
            dy_mag_r[i]    <= SPD_MIN;
`endif
         end
      end else begin
         active_d_r    <= game_active;
         point_pulse_r <= 1'b0;
         case (game_r)
            G_IDLE, G_OVER: begin
               if (game_active && !active_d_r) begin
                  game_r      <= G_PLAY;
                  score1_r    <= 4'd0;
                  score2_r    <= 4'd0;
                  speed_r     <= SPD_MIN;
                  tick_cnt_r  <= '0;
                  game_over_r <= 1'b0;
                  for (int i = 0; i < NUM_BALLS; i++) begin
                     bstate_r[i]    <= ball_enable[i] ? B_SERVE : B_PARKED;
                     bx_r[i]        <= CX;
                     by_r[i]        <= CY;
                     serve_cnt_r[i] <= '0;
                     dx_left_r[i]   <= serve_left(i);
                     dy_up_r[i]     <= serve_up(i);
`ifdef SPIN_DEFLECT_EN
                     dy_mag_r[i]    <= SPD_MIN;
`endif
                  end
               end else begin
                  game_r <= game_r;
               end
            end
            G_PLAY: begin
               if (!game_active) begin
                  game_r <= G_IDLE;
                  for (int i = 0; i < NUM_BALLS; i++) begin
                     bstate_r[i] <= B_PARKED;
                     bx_r[i]     <= CX;
                     by_r[i]     <= CY;
                  end
               end else if (refresh_tick) begin
                  if (tick_cnt_r == STEP_LAST) begin
                     tick_cnt_r <= '0;
                     speed_r    <= (speed_r < SPD_MAX) ? (speed_r + 4'd1) : speed_r;
                  end else begin
                     tick_cnt_r <= tick_cnt_r + 1'b1;
                  end

                  for (int i = 0; i < NUM_BALLS; i++) begin
                     if (!ball_enable[i]) begin
                        bstate_r[i] <= B_PARKED;
                        bx_r[i]     <= CX;
                        by_r[i]     <= CY;
                     end else begin
                        case (bstate_r[i])
                           B_PARKED: begin
                              bstate_r[i]    <= B_SERVE;
                              bx_r[i]        <= CX;
                              by_r[i]        <= CY;
                              serve_cnt_r[i] <= '0;
                              dx_left_r[i]   <= serve_left(i);
                              dy_up_r[i]     <= serve_up(i);
`ifdef SPIN_DEFLECT_EN
                              dy_mag_r[i]    <= speed_r;
`endif
                           end
                           B_SERVE: begin
                              if (serve_cnt_r[i] == SERVE_LAST) begin
                                 bstate_r[i] <= B_MOVE;
                              end else begin
                                 serve_cnt_r[i] <= serve_cnt_r[i] + 1'b1;
                              end
                           end
                           B_MOVE: begin
                              if (out_l_s[i] || out_r_s[i]) begin
                                 // losers of the same-tick priority stay put and retry next tick
                                 if (score_idx_s == IDXW'(i)) begin
                                    bstate_r[i]    <= B_SERVE;
                                    bx_r[i]        <= CX;
                                    by_r[i]        <= CY;
                                    serve_cnt_r[i] <= '0;
                                    dx_left_r[i]   <= out_r_s[i];
                                    dy_up_r[i]     <= serve_up(i);
`ifdef SPIN_DEFLECT_EN
                                    dy_mag_r[i]    <= speed_r;
`endif
                                 end else begin
                                    bstate_r[i] <= B_MOVE;
                                 end
                              end else begin
                                 if (hit_l_s[i]) begin
                                    bx_r[i]      <= L_CLAMP;
                                    dx_left_r[i] <= 1'b0;
`ifdef SPIN_DEFLECT_EN
                                    dy_mag_r[i]  <= spin_mag_s[i];
`endif
                                 end else if (hit_r_s[i]) begin
                                    bx_r[i]      <= R_CLAMP;
                                    dx_left_r[i] <= 1'b1;
`ifdef SPIN_DEFLECT_EN
                                    dy_mag_r[i]  <= spin_mag_s[i];
`endif
                                 end else begin
                                    bx_r[i] <= nx_s[i][9:0];
                                 end
                                 if (ny_s[i] <= TOP_S) begin
                                    by_r[i]    <= TOP_Y;
                                    dy_up_r[i] <= 1'b0;
                                 end else if (ny_s[i] >= BOT_S) begin
                                    by_r[i]    <= BOT_Y;
                                    dy_up_r[i] <= 1'b1;
                                 end else begin
                                    by_r[i] <= ny_s[i][9:0];
                                 end
                              end
                           end
                           default: begin
                              bstate_r[i] <= B_PARKED;
                              bx_r[i]     <= CX;
                              by_r[i]     <= CY;
                           end
                        endcase
                     end
                  end

                  if (score_found_s) begin
                     point_pulse_r <= 1'b1;
                     point_side_r  <= score_left_s;
                     if (score_left_s) begin
                        score2_r <= score2_r + 4'd1;
                     end else begin
                        score1_r <= score1_r + 4'd1;
                     end
                     if ((score_left_s && ((score2_r + 4'd1) == LIMIT)) ||
                         (!score_left_s && ((score1_r + 4'd1) == LIMIT))) begin
                        game_r      <= G_OVER;
                        game_over_r <= 1'b1;
                        for (int i = 0; i < NUM_BALLS; i++) begin
                           bstate_r[i] <= B_PARKED;
                           bx_r[i]     <= CX;
                           by_r[i]     <= CY;
                        end
                     end else begin
                        game_r <= G_PLAY;
                     end
                  end else begin
                     point_side_r <= point_side_r;
                  end
               end else begin
                  game_r <= G_PLAY;
               end
            end
            default: game_r <= G_IDLE;
         endcase
      end
   end

   assign score_player1 = score1_r;
   assign score_player2 = score2_r;
   assign speed         = speed_r;
   assign game_over     = game_over_r;
   assign point_pulse   = point_pulse_r;
   assign point_side    = point_side_r;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed vector bench for pong_ball_engine: serve, walls, paddles, scoring, speed ramp, game over.
module tb_pong_ball_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        refresh_tick;
   logic        game_active;
   logic [3:0]  ball_enable;
   logic [9:0]  paddle1_y;
   logic [9:0]  paddle2_y;
   logic [39:0] ball_x;
   logic [39:0] ball_y;
   logic [3:0]  ball_visible;
   logic [3:0]  score_player1;
   logic [3:0]  score_player2;
   logic [3:0]  speed;
   logic        game_over;
   logic        point_pulse;
   logic        point_side;

   always #5 clk = ~clk;

   pong_ball_engine dut (
      .clk           (clk),
      .reset         (reset),
      .refresh_tick  (refresh_tick),
      .game_active   (game_active),
      .ball_enable   (ball_enable),
      .paddle1_y     (paddle1_y),
      .paddle2_y     (paddle2_y),
      .ball_x        (ball_x),
      .ball_y        (ball_y),
      .ball_visible  (ball_visible),
      .score_player1 (score_player1),
      .score_player2 (score_player2),
      .speed         (speed),
      .game_over     (game_over),
      .point_pulse   (point_pulse),
      .point_side    (point_side)
   );

   typedef struct {
      int tick;
      int x0;
      int y0;
      int x1;
      int s1;
      int s2;
      int vis;
      int pulse;
      int side;
   } vec_t;

   vec_t vecs [10];
   int   checks = 0;
   int   errors = 0;
   int   t = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_tick();
      @(negedge clk);
      refresh_tick = 1'b1;
      @(negedge clk);
      refresh_tick = 1'b0;
      t++;
   endtask

   task automatic run_to(input int target);
      while (t < target) do_tick();
   endtask

   task automatic start_game();
      @(negedge clk);
      game_active = 1'b0;
      @(negedge clk);
      game_active = 1'b1;
      @(negedge clk);
      t = 0;
   endtask

   initial begin
      // cumulative ticks after game start, balls 0 and 1 enabled, paddles out of reach
      vecs[0] = '{60,  316, 248, 316, 0, 0, 3, 0, -1};
      vecs[1] = '{61,  314, 250, 318, 0, 0, 3, 0, -1};
      vecs[2] = '{62,  312, 252, 320, 0, 0, 3, 0, -1};
      vecs[3] = '{172,  92, 472, 540, 0, 0, 3, 0, -1};
      vecs[4] = '{173,  90, 470, 542, 0, 0, 3, 0, -1};
      vecs[5] = '{218,   0, 380, 632, 0, 0, 3, 0, -1};
      vecs[6] = '{219, 316, 248, 632, 0, 1, 3, 1,  1};
      vecs[7] = '{220, 316, 248, 316, 1, 1, 3, 1,  0};
      vecs[8] = '{280, 318, 250, 316, 1, 1, 3, 0, -1};
      vecs[9] = '{281, 320, 252, 314, 1, 1, 3, 0, -1};

      reset        = 1'b1;
      refresh_tick = 1'b0;
      game_active  = 1'b0;
      ball_enable  = 4'b0011;
      paddle1_y    = 10'd500;
      paddle2_y    = 10'd500;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check("reset_x0", ball_x[9:0], 316);
      check("reset_y0", ball_y[9:0], 248);
      check("reset_vis", ball_visible, 0);
      check("reset_s1", score_player1, 0);
      check("reset_s2", score_player2, 0);
      check("reset_speed", speed, 2);
      check("reset_over", game_over, 0);
      check("reset_pulse", point_pulse, 0);

      start_game();
      check("start_vis", ball_visible, 3);

      for (int i = 0; i < 10; i++) begin
         run_to(vecs[i].tick);
         check($sformatf("v%0d_x0", i), ball_x[9:0], vecs[i].x0);
         check($sformatf("v%0d_y0", i), ball_y[9:0], vecs[i].y0);
         check($sformatf("v%0d_x1", i), ball_x[19:10], vecs[i].x1);
         check($sformatf("v%0d_s1", i), score_player1, vecs[i].s1);
         check($sformatf("v%0d_s2", i), score_player2, vecs[i].s2);
         check($sformatf("v%0d_vis", i), ball_visible, vecs[i].vis);
         check($sformatf("v%0d_pulse", i), point_pulse, vecs[i].pulse);
         check($sformatf("v%0d_speed", i), speed, 2);
         if (vecs[i].side >= 0) check($sformatf("v%0d_side", i), point_side, vecs[i].side);
      end
      @(negedge clk);
      check("pulse_one_clk", point_pulse, 0);

      begin : wait_over
         int n;
         n = 0;
         while (game_over !== 1'b1 && n < 4000) begin
            do_tick();
            n++;
         end
         check("over_reached", game_over, 1);
         check("over_vis", ball_visible, 0);
         check("over_one_at_limit", 32'((score_player1 == 4'd5) + (score_player2 == 4'd5)), 1);
      end
      repeat (5) do_tick();
      check("over_hold", game_over, 1);
      check("over_vis_hold", ball_visible, 0);

      ball_enable = 4'b0000;
      paddle1_y   = 10'd394;
      start_game();
      check("restart_over", game_over, 0);
      check("restart_s1", score_player1, 0);
      check("restart_s2", score_player2, 0);
      check("restart_speed", speed, 2);
      check("restart_vis", ball_visible, 0);

      run_to(599);
      check("speed_599", speed, 2);
      run_to(600);
      check("speed_600", speed, 3);

      // ball 0 at speed 3 meets the top quarter of the left paddle (span 419..491)
      ball_enable = 4'b0001;
      run_to(661);
      check("sp3_serve_x", ball_x[9:0], 316);
      run_to(662);
      check("sp3_first_x", ball_x[9:0], 313);
      check("sp3_first_y", ball_y[9:0], 251);
      run_to(752);
      check("pad_pre_x", ball_x[9:0], 43);
      check("pad_pre_y", ball_y[9:0], 424);
      run_to(753);
      check("pad_hit_x", ball_x[9:0], 41);
      check("pad_hit_y", ball_y[9:0], 421);
      run_to(754);
      check("pad_after_x", ball_x[9:0], 44);
`ifdef SPIN_DEFLECT_EN
      check("pad_after_y", ball_y[9:0], 417);
`else
      check("pad_after_y", ball_y[9:0], 418);
`endif
      ball_enable = 4'b0000;
      run_to(755);
      check("disable_vis", ball_visible, 0);
      check("disable_x", ball_x[9:0], 316);

      run_to(1199);
      check("speed_1199", speed, 3);
      run_to(1200);
      check("speed_1200", speed, 4);
      run_to(1800);
      check("speed_1800", speed, 5);
      run_to(2400);
      check("speed_2400", speed, 5);

      ball_enable = 4'b0001;
      do_tick();
      check("late_enable_vis", ball_visible, 1);
      @(negedge clk);
      game_active = 1'b0;
      @(negedge clk);
      check("fall_vis", ball_visible, 0);
      check("fall_over", game_over, 0);
      game_active = 1'b1;
      @(negedge clk);
      check("rise_vis", ball_visible, 1);
      check("rise_speed", speed, 2);
      reset = 1'b1;
      #1;
      check("midreset_vis", ball_visible, 0);
      check("midreset_x0", ball_x[9:0], 316);
      @(negedge clk);
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
